csr_arbiter: RTL and testbench
==============================

CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive lost arbitration cycles after which core wins over trap.
REQ-002 Parameter HOLD_MAX, default 16, SHALL set the maximum number of consecutive granted cycles per requester before a forced release.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 core_req, trap_req  in  1 each  request; held high for the whole transaction.
REQ-006 core_we, trap_we  in  1 each  write enable for the requester's current cycle.
REQ-007 core_ra, core_wa, trap_ra, trap_wa  in  CSR_ADDR_W each  read and write CSR address.
REQ-008 core_wd, trap_wd  in  XLEN each  write data.
REQ-009 core_gnt, trap_gnt  out  1 each  grant, held while the requester owns the CSR port.
REQ-010 core_rd, trap_rd  out  XLEN each  read data returned to the owner.
REQ-011 core_err, trap_err  out  1 each  CSR error returned to the owner.
REQ-012 csr_ra, csr_wa  out  CSR_ADDR_W  CSR file read and write addresses.
REQ-013 csr_we  out  1  CSR file write enable.
REQ-014 csr_wd  out  XLEN  CSR file write data.
REQ-015 csr_rd  in  XLEN  CSR file read data (combinational read).
REQ-016 csr_err  in  1  CSR file error (illegal address or privilege).
REQ-017 timeout  out  1  one-cycle pulse on a forced release.

Function
REQ-018 FSM states SHALL be IDLE, CORE, TRAP, registered; gnt_x = (state==X), so a grant appears one cycle after req is sampled in IDLE.
REQ-019 IDLE SHALL resolve requests as follows: trap_req only -> TRAP; core_req only -> CORE; both -> TRAP, unless starve_cnt==STARVE_LIMIT, then CORE; none -> IDLE.
REQ-020 The owner's req SHALL lock the grant: a CORE or TRAP state is never preempted while the owner's req is high, except by timeout.
REQ-021 When the owner drops req, the FSM SHALL move next cycle to the other state if the other req is high (no IDLE bubble), else to IDLE.
REQ-022 While granted, csr_ra, csr_wa and csr_wd SHALL mux the owner's inputs, with csr_we = owner_we & owner_req; owner_rd = csr_rd and owner_err = csr_err, both combinational.
REQ-023 The non-owner's rd and err, and all csr_* outputs in IDLE, SHALL be 0.
REQ-024 starve_cnt SHALL increment each cycle that core_req=1 and state!=CORE, saturate at STARVE_LIMIT, and clear on entry to CORE.
REQ-025 hold_cnt SHALL clear on every grant entry and increment each granted cycle.
REQ-026 At hold_cnt==HOLD_MAX-1 with owner req still high, next state SHALL be IDLE, timeout SHALL pulse for 1 cycle in that transition cycle, and csr_we SHALL be forced 0 in that cycle.
REQ-027 After a timeout, a per-requester blocked flag SHALL be set; a blocked requester SHALL not be granted until its req is seen low, which clears the flag.
REQ-028 Simultaneous release and timeout in the same cycle SHALL be treated as a release: no timeout pulse and no block.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set state=IDLE, starve_cnt=0, hold_cnt=0, both blocked flags=0, timeout=0 and both gnt=0.
REQ-030 Combinational outputs SHALL follow IDLE values (all 0) from the first cycle after reset.
REQ-031 Reset asserted mid-transaction SHALL abort the grant without a timeout pulse.

Structure
REQ-032 arb_state_t SHALL be declared in core_config_pkg; XLEN and CSR_ADDR_W SHALL be imported from core_config_pkg.
REQ-033 STARVE_LIMIT and HOLD_MAX SHALL be module parameters.
REQ-034 The block SHALL be a single module with no sub-modules; counter widths SHALL be $clog2(param+1).

Verification
REQ-035 Scenario 1: core_req=1, we=1, wa=0x300, wd=0xDEADBEEF -> core_gnt in cycle 2, csr_we=1, csr_wa=0x300, csr_wd=0xDEADBEEF.
REQ-036 Scenario 2: core_req and trap_req rise in the same cycle -> trap_gnt first; after trap_req drops, core_gnt the next cycle with no IDLE cycle.
REQ-037 Scenario 3: trap_req held continuously with 1-cycle drops, core_req high -> core granted no later than STARVE_LIMIT (4) cycles of loss.
REQ-038 Scenario 4: core holds req for 20 cycles -> forced release after 16 granted cycles, timeout=1 for 1 cycle, no regrant until core_req low.
REQ-039 Scenario 5: rst=1 during TRAP with trap_we=1 -> next cycle all outputs 0, state IDLE, no timeout pulse.
REQ-040 Scenario 6: csr_err=1 during CORE -> core_err=1 and trap_err=0 in the same cycle.

Source files
------------

// File: rtl/core_config_pkg.sv
// Shared core configuration: datapath widths and the CSR arbiter state encoding.
package core_config_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CSR_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    TRAP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/csr_arbiter.sv
// Two-requester (core / trap) arbiter for the single CSR file port, with
// starvation protection for the core and a bounded hold time per grant.
module csr_arbiter
  import core_config_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned HOLD_MAX     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [CSR_ADDR_W-1:0] core_ra,
  input  logic [CSR_ADDR_W-1:0] core_wa,
  input  logic [XLEN-1:0]       core_wd,
  output logic                  core_gnt,
  output logic [XLEN-1:0]       core_rd,
  output logic                  core_err,
  input  logic                  trap_req,
  input  logic                  trap_we,
  input  logic [CSR_ADDR_W-1:0] trap_ra,
  input  logic [CSR_ADDR_W-1:0] trap_wa,
  input  logic [XLEN-1:0]       trap_wd,
  output logic                  trap_gnt,
  output logic [XLEN-1:0]       trap_rd,
  output logic                  trap_err,
  output logic [CSR_ADDR_W-1:0] csr_ra,
  output logic [CSR_ADDR_W-1:0] csr_wa,
  output logic                  csr_we,
  output logic [XLEN-1:0]       csr_wd,
  input  logic [XLEN-1:0]       csr_rd,
  input  logic                  csr_err,
  output logic                  timeout
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT);
  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_MAX - 1);

  arb_state_t            state_q, state_d;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  core_blk_q, core_blk_d;
  logic                  trap_blk_q, trap_blk_d;

  logic core_eff;
  logic trap_eff;
  logic granted;
  logic owner_req;
  logic hold_expired;
  logic timeout_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      hold_cnt_q   <= '0;
      core_blk_q   <= 1'b0;
      trap_blk_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      core_blk_q   <= core_blk_d;
      trap_blk_q   <= trap_blk_d;
    end
  end

  // A requester blocked by a previous timeout is invisible to arbitration.
  always_comb begin
    core_eff     = core_req & ~core_blk_q;
    trap_eff     = trap_req & ~trap_blk_q;
    granted      = (state_q == CORE) || (state_q == TRAP);
    owner_req    = 1'b0;
    if (state_q == CORE) owner_req = core_req;
    if (state_q == TRAP) owner_req = trap_req;
    hold_expired = (hold_cnt_q == HOLD_LAST);
    // Owner releasing in its final cycle counts as a release, not a timeout.
    timeout_c    = granted & owner_req & hold_expired;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trap_eff && core_eff)
          state_d = (starve_cnt_q == STARVE_TOP) ? CORE : TRAP;
        else if (trap_eff)
          state_d = TRAP;
        else if (core_eff)
          state_d = CORE;
        else
          state_d = IDLE;
      end
      CORE: begin
        if (!core_req)
          state_d = trap_eff ? TRAP : IDLE;
        else if (hold_expired)
          state_d = IDLE;
        else
          state_d = CORE;
      end
      TRAP: begin
        if (!trap_req)
          state_d = core_eff ? CORE : IDLE;
        else if (hold_expired)
          state_d = IDLE;
        else
          state_d = TRAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if ((state_d == CORE) && (state_q != CORE))
      starve_cnt_d = '0;
    else if (core_req && (state_q != CORE) && (starve_cnt_q != STARVE_TOP))
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);

    hold_cnt_d = hold_cnt_q;
    if ((state_d != IDLE) && (state_d != state_q))
      hold_cnt_d = '0;
    else if (granted)
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);

    core_blk_d = core_blk_q;
    if (!core_req)
      core_blk_d = 1'b0;
    else if (timeout_c && (state_q == CORE))
      core_blk_d = 1'b1;

    trap_blk_d = trap_blk_q;
    if (!trap_req)
      trap_blk_d = 1'b0;
    else if (timeout_c && (state_q == TRAP))
      trap_blk_d = 1'b1;
  end

  always_comb begin
    core_gnt = (state_q == CORE);
    trap_gnt = (state_q == TRAP);
    timeout  = timeout_c & ~rst;
    csr_ra   = '0;
    csr_wa   = '0;
    csr_wd   = '0;
    csr_we   = 1'b0;
    core_rd  = '0;
    core_err = 1'b0;
    trap_rd  = '0;
    trap_err = 1'b0;
    case (state_q)
      CORE: begin
        csr_ra   = core_ra;
        csr_wa   = core_wa;
        csr_wd   = core_wd;
        csr_we   = core_we & core_req & ~timeout_c;
        core_rd  = csr_rd;
        core_err = csr_err;
      end
      TRAP: begin
        csr_ra   = trap_ra;
        csr_wa   = trap_wa;
        csr_wd   = trap_wd;
        csr_we   = trap_we & trap_req & ~timeout_c;
        trap_rd  = csr_rd;
        trap_err = csr_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed checks of csr_arbiter: muxing, arbitration order, starvation,
// hold timeout with blocking, and mid-transaction reset.
module tb_csr_arbiter;
  import core_config_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  core_req, core_we, trap_req, trap_we;
  logic [CSR_ADDR_W-1:0] core_ra, core_wa, trap_ra, trap_wa;
  logic [XLEN-1:0]       core_wd, trap_wd;
  logic                  core_gnt, trap_gnt, core_err, trap_err;
  logic [XLEN-1:0]       core_rd, trap_rd;
  logic [CSR_ADDR_W-1:0] csr_ra, csr_wa;
  logic                  csr_we;
  logic [XLEN-1:0]       csr_wd, csr_rd;
  logic                  csr_err;
  logic                  timeout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  csr_arbiter #(.STARVE_LIMIT(4), .HOLD_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_ra(core_ra), .core_wa(core_wa),
    .core_wd(core_wd), .core_gnt(core_gnt), .core_rd(core_rd), .core_err(core_err),
    .trap_req(trap_req), .trap_we(trap_we), .trap_ra(trap_ra), .trap_wa(trap_wa),
    .trap_wd(trap_wd), .trap_gnt(trap_gnt), .trap_rd(trap_rd), .trap_err(trap_err),
    .csr_ra(csr_ra), .csr_wa(csr_wa), .csr_we(csr_we), .csr_wd(csr_wd),
    .csr_rd(csr_rd), .csr_err(csr_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    core_req = 0; core_we = 0; core_ra = '0; core_wa = '0; core_wd = '0;
    trap_req = 0; trap_we = 0; trap_ra = '0; trap_wa = '0; trap_wd = '0;
    csr_rd = '0; csr_err = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    check_eq("rst_core_gnt", core_gnt, 0);
    check_eq("rst_trap_gnt", trap_gnt, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_csr_we", csr_we, 0);

    // Single core write
    core_req = 1; core_we = 1; core_wa = 12'h300; core_wd = 32'hDEADBEEF; core_ra = 12'h305;
    #1;
    check_eq("s1_c1_gnt", core_gnt, 0);
    check_eq("s1_c1_wa_idle", csr_wa, 0);
    check_eq("s1_c1_we_idle", csr_we, 0);
    tick();
    check_eq("s1_c2_gnt", core_gnt, 1);
    check_eq("s1_c2_we", csr_we, 1);
    check_eq("s1_c2_wa", csr_wa, 64'h300);
    check_eq("s1_c2_wd", csr_wd, 64'hDEADBEEF);
    check_eq("s1_c2_ra", csr_ra, 64'h305);
    csr_rd = 32'h12345678;
    #1;
    check_eq("s1_core_rd", core_rd, 64'h12345678);
    check_eq("s1_trap_rd", trap_rd, 0);
    csr_err = 1;
    #1;
    check_eq("s6_core_err", core_err, 1);
    check_eq("s6_trap_err", trap_err, 0);
    core_we = 0;
    #1;
    check_eq("s1_we_drop", csr_we, 0);
    core_req = 0;
    tick();
    check_eq("s1_idle_gnt", core_gnt, 0);
    check_eq("s1_idle_rd", core_rd, 0);
    check_eq("s1_idle_err", core_err, 0);
    check_eq("s1_idle_wa", csr_wa, 0);
    clear_inputs();

    // Simultaneous requests: trap first, then handoff to core without IDLE
    core_req = 1; trap_req = 1; trap_we = 1; trap_wa = 12'h341; trap_wd = 32'h0000A5A5;
    tick();
    check_eq("s2_trap_gnt", trap_gnt, 1);
    check_eq("s2_core_gnt0", core_gnt, 0);
    check_eq("s2_wa", csr_wa, 64'h341);
    check_eq("s2_we", csr_we, 1);
    tick();
    trap_req = 0;
    #1;
    check_eq("s2_we_reqlow", csr_we, 0);
    tick();
    check_eq("s2_handoff_core", core_gnt, 1);
    check_eq("s2_handoff_trap", trap_gnt, 0);
    core_req = 0;
    tick();
    check_eq("s2_idle", core_gnt, 0);
    clear_inputs();

    // Starvation: below limit trap wins, at limit core wins
    core_req = 1; trap_req = 1;
    tick();
    check_eq("s3_t1_trap", trap_gnt, 1);
    core_req = 0; trap_req = 0;
    tick();
    check_eq("s3_idle_a", trap_gnt, 0);
    core_req = 1; trap_req = 1;
    tick();
    check_eq("s3_below_limit_trap", trap_gnt, 1);
    tick();
    tick();
    check_eq("s3_still_trap", trap_gnt, 1);
    core_req = 0; trap_req = 0;
    tick();
    check_eq("s3_idle_b", trap_gnt, 0);
    core_req = 1; trap_req = 1;
    tick();
    check_eq("s3_starve_core", core_gnt, 1);
    check_eq("s3_starve_trap", trap_gnt, 0);
    core_req = 0;
    tick();
    check_eq("s3_handoff_trap", trap_gnt, 1);
    core_req = 1; trap_req = 0;
    tick();
    check_eq("s3_drop_core", core_gnt, 1);
    core_req = 0;
    tick();
    check_eq("s3_idle_c", core_gnt, 0);
    clear_inputs();

    // Hold timeout: 16 granted cycles, one-cycle pulse, blocked until req low
    core_req = 1; core_we = 1; core_wa = 12'h340;
    tick();
    for (int g = 1; g <= 16; g++) begin
      check_eq($sformatf("s4_gnt_%0d", g), core_gnt, 1);
      check_eq($sformatf("s4_to_%0d", g), timeout, (g == 16) ? 1 : 0);
      check_eq($sformatf("s4_we_%0d", g), csr_we, (g == 16) ? 0 : 1);
      if (g < 16) tick();
    end
    tick();
    check_eq("s4_release_gnt", core_gnt, 0);
    check_eq("s4_release_to", timeout, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("s4_blocked_%0d", k), core_gnt, 0);
    end
    core_req = 0;
    tick();
    check_eq("s4_reqlow_gnt", core_gnt, 0);
    core_req = 1;
    tick();
    check_eq("s4_regrant", core_gnt, 1);
    check_eq("s4_regrant_to", timeout, 0);

    // Release in the final hold cycle is a release, not a timeout
    for (int g = 2; g <= 16; g++) tick();
    check_eq("s4b_last_gnt", core_gnt, 1);
    core_req = 0;
    #1;
    check_eq("s4b_no_timeout", timeout, 0);
    tick();
    check_eq("s4b_idle", core_gnt, 0);
    core_req = 1;
    tick();
    check_eq("s4b_not_blocked", core_gnt, 1);
    core_req = 0;
    tick();
    clear_inputs();

    // Reset during a trap write
    trap_req = 1; trap_we = 1; trap_wa = 12'h7C0; trap_wd = 32'h55AA55AA;
    tick();
    check_eq("s5_trap_gnt", trap_gnt, 1);
    check_eq("s5_we", csr_we, 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    check_eq("s5_gnt", trap_gnt, 0);
    check_eq("s5_core_gnt", core_gnt, 0);
    check_eq("s5_we_after", csr_we, 0);
    check_eq("s5_wa_after", csr_wa, 0);
    check_eq("s5_wd_after", csr_wd, 0);
    check_eq("s5_timeout", timeout, 0);
    tick();
    check_eq("s5_regrant", trap_gnt, 1);
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
